gpr_file_sb: RTL and testbench

Parametrised general-purpose register file with a per-register pending-write scoreboard, for the pipelined core. It provides NRD combinational read ports and two write ports, W0 (older producer) and W1 (younger producer), with same-cycle write-to-read bypass. Per-register outstanding-write counters let the hazard unit stall on operands that are still in flight. The block sits in the decode stage: issue allocates destinations, and writeback retires them.

---
 rtl/gpr_file_sb.sv | 166 ++++++++++++++++
 tb/tb_gpr_file_sb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_sb.sv
// gpr_file_sb
//   General-purpose register file with a per-register pending-write
//   scoreboard. Issue allocates destinations (alloc_*); writeback retires
//   them through the two write ports. Register 0 reads as zero and ignores
//   writes and allocations.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   ra / rd             NRD combinational read ports with write bypass
//   rd_busy             per read port: operand still pending after this
//                       cycle's writes retire
//   we0/wa0/wd0         write port 0 (older producer)
//   we1/wa1/wd1         write port 1 (younger producer, wins on same address)
//   alloc_en/alloc_a    record one more outstanding write for alloc_a
//   flush               drop all outstanding allocations
//   err_ovf / err_unf   sticky counter overflow / underflow flags
module gpr_file_sb #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_a,
  input  logic                  flush,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam int DEPTH = 1 << AW;
  // Counter arithmetic is done two bits wider than the counter so that
  // "count - writes" can be compared without wrap and "+1" can exceed max.
  localparam int CW = CNT_W + 2;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << CNT_W) - 1);

  // ------------------------------------------------------------------
  // Register array
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we0 && (wa0 != '0)) regs_d[wa0] = wd0;
    // Applied second so the younger producer wins on a shared address.
    if (we1 && (wa1 != '0)) regs_d[wa1] = wd1;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) regs_q[a] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ------------------------------------------------------------------
  // Scoreboard counters
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic [DEPTH-1:0] ovf_hit;
  logic [DEPTH-1:0] unf_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
    if (gi == 0) begin : g_zero
      assign cnt_d[gi]   = '0;
      assign ovf_hit[gi] = 1'b0;
      assign unf_hit[gi] = 1'b0;
    end else begin : g_live
      logic          hit0, hit1, hit_a;
      logic [CW-1:0] nwr, base, dec, inc;

      assign hit0  = we0 && (wa0 == AW'(gi));
      assign hit1  = we1 && (wa1 == AW'(gi));
      assign hit_a = alloc_en && (alloc_a == AW'(gi));

      always_comb begin
        nwr  = CW'(hit0) + CW'(hit1);
        // Writes still retire against the flushed (zero) base, so an
        // allocation in the flush cycle survives.
        base = flush ? '0 : CW'(cnt_q[gi]);
        dec  = (base > nwr) ? (base - nwr) : '0;
        inc  = dec + CW'(hit_a);
      end

      // Only a net result above max is an overflow; a same-cycle retire
      // makes room for the allocation.
      assign ovf_hit[gi] = (inc > CNT_MAX);
      assign cnt_d[gi]   = (inc > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : inc[CNT_W-1:0];
      assign unf_hit[gi] = !flush && (nwr > CW'(cnt_q[gi]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) cnt_q[a] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Sticky error flags
  // ------------------------------------------------------------------
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (|ovf_hit);
    err_unf_d = err_unf_q | (|unf_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

  // ------------------------------------------------------------------
  // Read ports with bypass and busy
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              rhit0, rhit1;
    logic [DATA_W-1:0] data;
    logic [CW-1:0]     rnwr;

    assign addr  = ra[gi*AW +: AW];
    assign rhit0 = we0 && (wa0 == addr);
    assign rhit1 = we1 && (wa1 == addr);
    assign rnwr  = CW'(rhit0) + CW'(rhit1);

    always_comb begin
      data = regs_q[addr];
      if (addr == '0)  data = '0;
      else if (rhit1)  data = wd1;
      else if (rhit0)  data = wd0;
    end

    assign rd[gi*DATA_W +: DATA_W] = data;
    // Busy looks only at current counts minus this cycle's retires;
    // flush and alloc take effect from the next cycle.
    assign rd_busy[gi] = (addr != '0) && (CW'(cnt_q[addr]) > rnwr);
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int CW   = 2;
  localparam int NREG = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk;
  logic              reset_n;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    rd_busy;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic              alloc_en;
  logic [AW-1:0]     alloc_a;
  logic              flush;
  logic              err_ovf, err_unf;

  gpr_file_sb #(.DATA_W(DW), .AW(AW), .NRD(NRD), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_a(alloc_a), .flush(flush),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [DW-1:0] m_mem [NREG];
  int            m_cnt [NREG];
  logic          m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nwr(input int a);
    int n = 0;
    if (we0 && int'(wa0) == a) n++;
    if (we1 && int'(wa1) == a) n++;
    return n;
  endfunction

  function automatic int port_a(input int p);
    logic [AW-1:0] a;
    a = ra[p*AW +: AW];
    return int'(a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int p);
    int a = port_a(p);
    if (a == 0) return '0;
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int p);
    int a = port_a(p);
    return (a != 0) && (m_cnt[a] - nwr(a) > 0);
  endfunction

  task automatic model_clear();
    for (int a = 0; a < NREG; a++) begin
      m_mem[a] = '0;
      m_cnt[a] = 0;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update();
    int v;
    int n;
    for (int a = 1; a < NREG; a++) begin
      n = nwr(a);
      if (!flush && n > m_cnt[a]) m_unf = 1'b1;
      v = (flush ? 0 : m_cnt[a]) - n;
      if (v < 0) v = 0;
      if (alloc_en && int'(alloc_a) == a) v++;
      if (v > CMAX) begin
        v = CMAX;
        m_ovf = 1'b1;
      end
      m_cnt[a] = v;
    end
    if (we0 && wa0 != 0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 0) m_mem[wa1] = wd1;
  endtask

  // Check all outputs against the model for the current inputs.
  task automatic eval();
    if (!reset_n) model_clear();
    #2;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd%0d", p), 64'(rd[p*DW +: DW]), 64'(exp_rd(p)));
      chk($sformatf("busy%0d", p), 64'(rd_busy[p]), 64'(exp_busy(p)));
    end
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("err_unf", 64'(err_unf), 64'(m_unf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_update();
    #1;
  endtask

  task automatic idle();
    we0 = 0; wa0 = 0; wd0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0;
    alloc_en = 0; alloc_a = 0; flush = 0; ra = '0;
  endtask

  task automatic set_ra(input int p, input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    eval(); tick();
    reset_n = 1;
  endtask

  task automatic alloc_cycle(input int a);
    idle();
    alloc_en = 1; alloc_a = AW'(a);
    eval(); tick();
  endtask

  function automatic logic [AW-1:0] rnd_a();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    reset_n = 1;
    idle();
    model_clear();
    #1 reset_n = 0;

    // Reset / zero register
    we0 = 1; wa0 = 3; wd0 = 32'h11; set_ra(0, 3);
    eval();
    chk("rst_bypass", 64'(rd[0 +: DW]), 64'h11);
    tick();
    idle(); reset_n = 1; set_ra(0, 3);
    eval();
    chk("rst_no_write", 64'(rd[0 +: DW]), 64'h0);
    tick();
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; set_ra(0, 0);
    eval();
    chk("r0_bypass", 64'(rd[0 +: DW]), 64'h0);
    tick();
    idle();
    eval();
    chk("r0_read", 64'(rd[0 +: DW]), 64'h0);
    tick();

    // Dual write priority and bypass
    do_reset();
    we0 = 1; wa0 = 7; wd0 = 32'hA; we1 = 1; wa1 = 7; wd1 = 32'hB; set_ra(0, 7);
    eval();
    chk("dual_bypass", 64'(rd[0 +: DW]), 64'hB);
    tick();
    idle(); set_ra(0, 7);
    eval();
    chk("dual_array", 64'(rd[0 +: DW]), 64'hB);
    tick();
    we0 = 1; wa0 = 7; wd0 = 32'hA; we1 = 1; wa1 = 8; wd1 = 32'hB;
    set_ra(0, 7); set_ra(1, 8);
    eval();
    chk("split_byp0", 64'(rd[0 +: DW]), 64'hA);
    chk("split_byp1", 64'(rd[DW +: DW]), 64'hB);
    tick();
    idle(); set_ra(0, 7); set_ra(1, 8);
    eval();
    chk("split_arr0", 64'(rd[0 +: DW]), 64'hA);
    chk("split_arr1", 64'(rd[DW +: DW]), 64'hB);
    tick();

    // Scoreboard lifecycle
    do_reset();
    alloc_cycle(5);
    alloc_cycle(5);
    idle(); set_ra(0, 5);
    eval();
    chk("sb_busy2", 64'(rd_busy[0]), 64'h1);
    tick();
    we0 = 1; wa0 = 5; wd0 = 32'h501;
    eval();
    chk("sb_busy_w1", 64'(rd_busy[0]), 64'h1);
    tick();
    we0 = 1; wa0 = 5; wd0 = 32'h502;
    eval();
    chk("sb_busy_w2", 64'(rd_busy[0]), 64'h0);
    tick();
    idle(); set_ra(0, 5);
    eval();
    chk("sb_idle", 64'(rd_busy[0]), 64'h0);
    chk("sb_ovf", 64'(err_ovf), 64'h0);
    chk("sb_unf", 64'(err_unf), 64'h0);
    tick();

    // Overflow
    do_reset();
    for (int k = 0; k < 4; k++) alloc_cycle(9);
    idle(); set_ra(0, 9);
    eval();
    chk("ovf_flag", 64'(err_ovf), 64'h1);
    tick();
    // Retiring two writes only clears busy if the count is below 3.
    we0 = 1; wa0 = 9; we1 = 1; wa1 = 9; set_ra(0, 9);
    eval();
    chk("ovf_cnt3", 64'(rd_busy[0]), 64'h1);
    tick();

    // Underflow
    do_reset();
    we0 = 1; wa0 = 10; wd0 = 32'h55;
    eval(); tick();
    idle(); set_ra(0, 10);
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("unf_flag", 64'(err_unf), 64'h1);
      chk("unf_data", 64'(rd[0 +: DW]), 64'h55);
      tick();
    end
    do_reset();
    eval();
    chk("unf_cleared", 64'(err_unf), 64'h0);
    tick();

    // Flush interplay
    do_reset();
    alloc_cycle(4);
    alloc_cycle(4);
    alloc_cycle(6);
    idle();
    flush = 1; alloc_en = 1; alloc_a = 6; we0 = 1; wa0 = 4; wd0 = 32'h44;
    set_ra(0, 4); set_ra(1, 6);
    eval();
    chk("fl_busy4_now", 64'(rd_busy[0]), 64'h1);
    chk("fl_busy6_now", 64'(rd_busy[1]), 64'h1);
    tick();
    idle(); set_ra(0, 4); set_ra(1, 6);
    eval();
    chk("fl_cnt4", 64'(rd_busy[0]), 64'h0);
    chk("fl_cnt6", 64'(rd_busy[1]), 64'h1);
    chk("fl_unf", 64'(err_unf), 64'h0);
    chk("fl_data4", 64'(rd[0 +: DW]), 64'h44);
    tick();
    // cnt[6] must be exactly 1: one write clears it.
    we0 = 1; wa0 = 6; wd0 = 32'h66; set_ra(1, 6);
    eval();
    chk("fl_cnt6_is1", 64'(rd_busy[1]), 64'h0);
    tick();

    // Simultaneous alloc + write on a saturated counter
    do_reset();
    for (int k = 0; k < 3; k++) alloc_cycle(12);
    idle();
    alloc_en = 1; alloc_a = 12; we1 = 1; wa1 = 12; wd1 = 32'hC; set_ra(0, 12);
    eval();
    chk("aw_busy", 64'(rd_busy[0]), 64'h1);
    tick();
    idle();
    we0 = 1; wa0 = 12; we1 = 1; wa1 = 12; set_ra(0, 12);
    eval();
    chk("aw_ovf", 64'(err_ovf), 64'h0);
    chk("aw_cnt3", 64'(rd_busy[0]), 64'h1);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n  = ($urandom_range(0, 149) != 0);
      we0      = ($urandom_range(0, 2) == 0);
      wa0      = rnd_a();
      wd0      = $urandom;
      we1      = ($urandom_range(0, 2) == 0);
      wa1      = rnd_a();
      wd1      = $urandom;
      alloc_en = ($urandom_range(0, 1) == 0);
      alloc_a  = rnd_a();
      flush    = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < NRD; p++) set_ra(p, int'(rnd_a()));
      eval();
      tick();
    end
    reset_n = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
